bsg_store_and_forward_meta: RTL
===============================

Name: bsg_store_and_forward_meta

Overview:
- Packet store-and-forward FIFO, next generation of the single-channel store-and-forward buffer in the Ethernet controller.
- Buffers whole frames and releases only committed frames. Error-terminated and overflowing frames are discarded without stalling the input.
- Adds per-beat byte-keep storage, a frame-length metadata queue presented with each frame's first beat, a frame-count limit and drop-status pulses.
- Sits between MAC RX/TX framing logic and the DMA/CSR side.

Parameters:
- width_p, (none, required), data beat width in bits; must be a multiple of 8.
- lg_size_p, (none, required), log2 of the data buffer depth in beats.
- lg_frames_p, 2, log2 of the maximum number of committed frames held at once (length queue depth).
- keep_width_lp, width_p/8, derived; byte-keep width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- data_i  in  width_p  input beat
- keep_i  in  keep_width_lp  byte-valid mask; all-ones except on the last beat
- v_i  in  1  input valid
- last_i  in  1  last beat of frame
- error_i  in  1  frame bad; sampled only when last_i=1
- ready_and_o  out  1  input ready
- data_o  out  width_p  output beat
- keep_o  out  keep_width_lp  output mask
- len_o  out  lg_size_p+1  frame length in beats; valid with every beat of the frame
- v_o  out  1  output valid
- last_o  out  1  output last
- ready_and_i  in  1  output ready
- good_o  out  1  one-cycle pulse: frame committed
- bad_o  out  1  one-cycle pulse: frame dropped for error_i
- overflow_o  out  1  one-cycle pulse: frame dropped for lack of space

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values: all pointers 0, FSM e_idle, v_o=0, good_o/bad_o/overflow_o=0.
- ready_and_o is 1 whenever not in reset. The input is never back-pressured; frames are dropped instead.
- Storage:
  - 1r1w synchronous memory of 2^lg_size_p entries, each holding {data, keep, last}.
  - Pointers are lg_size_p+1 bits wide; the MSB disambiguates full from empty.
  - Three pointers: wr_commit, wr_cur, rd.
- Write FSM:
  - e_idle: on v_i, move to e_store and begin writing, unless the data buffer is full or the length queue is full; in that case go to e_drop.
  - e_store: write each beat at wr_cur and increment wr_cur and the beat counter.
    - Beat arrives while wr_cur==rd^MSB (buffer full): rewind wr_cur to wr_commit and go to e_drop. If that beat also has last_i, pulse overflow_o and return to e_idle.
    - last_i with error_i: rewind wr_cur to wr_commit, pulse bad_o, go to e_idle.
    - last_i without error: wr_commit<=wr_cur+1, push the beat count into the length queue, pulse good_o, go to e_idle.
  - e_drop: discard beats until last_i, then pulse overflow_o and go to e_idle.
  - A single-beat frame goes e_idle->commit in the same cycle it is accepted, with no e_store visit.
- Length arithmetic: the beat counter saturates at 2^lg_size_p. A frame longer than the buffer always ends via overflow.
- Read side:
  - Empty = rd==wr_commit.
  - Memory read is issued when not empty and the two-stage pipe (read-valid register plus 2-entry skid FIFO) can accept.
  - len_o is the head of the length queue; the queue pops on the handshake of an output beat with last_o=1.
- Latency: the first beat of a frame appears on v_o 2 cycles after its commit cycle when the output is idle. Steady-state throughput is 1 beat/cycle.
- Simultaneous events:
  - Commit and read in the same cycle are both honoured.
  - The length-queue push and pop in the same cycle keep the count unchanged.
  - Freeing space in the same cycle as a full check does not prevent the drop; the check uses registered pointers.
- Reset mid-frame: any partial frame is lost and the output pipe is flushed; the first input beat after reset is treated as a frame start.
- v_o/data_o obey valid-ready: once asserted, they are held until ready_and_i.

Optional Feature:
- Macro: BSG_STORE_AND_FORWARD_STATS_EN.
- Defined: three extra outputs good_cnt_o, bad_cnt_o and overflow_cnt_o, each 32 bits. Each increments on its pulse, saturates at 2^32-1 and resets to 0. Plus input stats_clear_i, which zeroes all three counters; clear wins over a same-cycle increment.
- Undefined: these ports and the counters do not exist.

Decomposition:
- Package bsg_store_and_forward_pkg:
  - write-FSM enum {e_idle, e_store, e_drop}
  - struct for the memory entry {data, keep, last}, parameterised through a typedef macro
- Sub-module bsg_store_and_forward_rd_pipe: memory read issue, read-valid register, 2-entry skid FIFO and length-queue pop. Keeps the read-side timing isolated from the write FSM.

Test Plan:
- Bench config for all cases: width_p=8, lg_size_p=4, lg_frames_p=2.
- Three frames of 3, 1, 5 beats with ready_and_i=1 -> output order preserved; len_o=3,1,5; three good_o pulses; first v_o 2 cycles after first commit.
- 4-beat frame with error_i on last, then a 2-beat good frame -> bad_o once; only the 2-beat frame appears, len_o=2.
- ready_and_i=0, send a 20-beat frame -> overflow_o on beat 20; no output. Then a 4-beat frame -> output with len_o=4.
- ready_and_i=0, five 1-beat frames -> four good_o; fifth gives overflow_o. Release ready -> exactly four beats emerge.
- Random ready_and_i toggling at 50% over 200 frames of random length 1..16, with a reference model -> data, keep and last match; no duplicate or lost beat.
- Assert reset_i on beat 3 of a 6-beat frame -> v_o=0 the next cycle; a new 2-beat frame after reset forwards correctly.

Source files
------------

// File: rtl/bsg_store_and_forward_pkg.sv
// Shared types for the store-and-forward packet FIFO: write-FSM states and the
// memory entry layout macro, sized by the data width of the instantiating module.
`ifndef BSG_STORE_AND_FORWARD_PKG_SV
`define BSG_STORE_AND_FORWARD_PKG_SV

`define BSG_SF_ENTRY_T(name, width) \
  typedef struct packed { \
    logic [(width)-1:0]   data; \
    logic [(width)/8-1:0] keep; \
    logic                 last; \
  } name

package bsg_store_and_forward_pkg;

  typedef enum logic [1:0] {e_idle, e_store, e_drop} sf_state_e;

endpackage

`endif

// File: rtl/bsg_store_and_forward_rd_pipe.sv
// Read side: memory read issue, read-valid register, 2-entry skid FIFO and
// the length-queue pop strobe. Output beats are valid-ready and held until taken.
module bsg_store_and_forward_rd_pipe
  import bsg_store_and_forward_pkg::*;
#(
  parameter int width_p = 8,
  parameter int lg_size_p = 4,
  localparam int keep_width_lp = width_p/8,
  localparam int entry_width_lp = width_p + keep_width_lp + 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [lg_size_p:0]        wr_commit_i,
  output logic [lg_size_p:0]        rd_ptr_o,
  output logic                      rd_en_o,
  output logic [lg_size_p-1:0]      rd_addr_o,
  input  logic [entry_width_lp-1:0] rd_data_i,
  output logic [width_p-1:0]        data_o,
  output logic [keep_width_lp-1:0]  keep_o,
  output logic                      v_o,
  output logic                      last_o,
  input  logic                      ready_and_i,
  output logic                      lenq_pop_o
);

  `BSG_SF_ENTRY_T(entry_s, width_p);

  logic [lg_size_p:0] rd_q;
  logic               rv_q;
  entry_s             skid_q [2];
  logic               skid_rptr_q, skid_wptr_q;
  logic [1:0]         skid_cnt_q;
  entry_s             head;
  logic               skid_empty, yumi, skid_push, skid_pop;

  assign skid_empty = (skid_cnt_q == 2'd0);
  // Beats in flight (skid + read register) never exceed the skid depth.
  assign rd_en_o    = (rd_q != wr_commit_i) &&
                      (skid_empty || ((skid_cnt_q == 2'd1) && !rv_q));
  assign rd_addr_o  = rd_q[lg_size_p-1:0];
  assign rd_ptr_o   = rd_q;

  assign head       = skid_empty ? entry_s'(rd_data_i) : skid_q[skid_rptr_q];
  assign v_o        = !skid_empty || rv_q;
  assign yumi       = v_o && ready_and_i;
  assign skid_push  = rv_q && !(skid_empty && ready_and_i);
  assign skid_pop   = yumi && !skid_empty;
  assign lenq_pop_o = yumi && head.last;

  assign data_o = head.data;
  assign keep_o = head.keep;
  assign last_o = head.last;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rd_q        <= '0;
      rv_q        <= 1'b0;
      skid_rptr_q <= 1'b0;
      skid_wptr_q <= 1'b0;
      skid_cnt_q  <= 2'd0;
    end else begin
      rv_q <= rd_en_o;
      if (rd_en_o) rd_q <= rd_q + (lg_size_p+1)'(1);
      if (skid_push) begin
        skid_q[skid_wptr_q] <= rd_data_i;
        skid_wptr_q         <= ~skid_wptr_q;
      end
      if (skid_pop) skid_rptr_q <= ~skid_rptr_q;
      skid_cnt_q <= skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};
    end
  end

endmodule

// File: rtl/bsg_store_and_forward_meta.sv
// Store-and-forward packet FIFO with per-beat keep, frame-length metadata and drop pulses.
// Define BSG_STORE_AND_FORWARD_STATS_EN to add saturating good/bad/overflow counters.
module bsg_store_and_forward_meta
  import bsg_store_and_forward_pkg::*;
#(
  parameter int width_p = 8,
  parameter int lg_size_p = 4,
  parameter int lg_frames_p = 2,
  localparam int keep_width_lp = width_p/8
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [keep_width_lp-1:0] keep_i,
  input  logic                     v_i,
  input  logic                     last_i,
  input  logic                     error_i,
  output logic                     ready_and_o,
  output logic [width_p-1:0]       data_o,
  output logic [keep_width_lp-1:0] keep_o,
  output logic [lg_size_p:0]       len_o,
  output logic                     v_o,
  output logic                     last_o,
  input  logic                     ready_and_i,
  output logic                     good_o,
  output logic                     bad_o,
  output logic                     overflow_o
`ifdef BSG_STORE_AND_FORWARD_STATS_EN
  ,
  input  logic                     stats_clear_i,
  output logic [31:0]              good_cnt_o,
  output logic [31:0]              bad_cnt_o,
  output logic [31:0]              overflow_cnt_o
`endif
);

  localparam int ptr_width_lp  = lg_size_p + 1;
  localparam int lenq_depth_lp = 1 << lg_frames_p;
  localparam logic [ptr_width_lp-1:0] one_ptr_lp = ptr_width_lp'(1);
  localparam logic [ptr_width_lp-1:0] size_lp    = ptr_width_lp'(1 << lg_size_p);
  localparam logic [lg_frames_p:0]    lenq_max_lp = (lg_frames_p+1)'(lenq_depth_lp);

  `BSG_SF_ENTRY_T(entry_s, width_p);

  entry_s                  mem [2**lg_size_p];
  entry_s                  mem_rdata_q;
  sf_state_e               state_q;
  logic [ptr_width_lp-1:0] wr_cur_q, wr_commit_q, cnt_q, rd_ptr;
  logic [ptr_width_lp-1:0] len_next, push_len;
  logic [lg_size_p-1:0]    rd_addr;
  logic                    rd_en, lenq_pop, lenq_push;
  logic                    buf_full, lenq_full, start_ok, wr_en;
  logic                    good_q, bad_q, overflow_q;

  logic [ptr_width_lp-1:0] lenq_mem [lenq_depth_lp];
  logic [lg_frames_p-1:0]  lenq_wptr_q, lenq_rptr_q;
  logic [lg_frames_p:0]    lenq_cnt_q;

  assign ready_and_o = !reset_i;
  // Full check uses registered pointers only; same-cycle reads do not rescue a beat.
  assign buf_full  = (wr_cur_q == {~rd_ptr[lg_size_p], rd_ptr[lg_size_p-1:0]});
  assign lenq_full = (lenq_cnt_q == lenq_max_lp);
  assign start_ok  = !buf_full && !lenq_full;
  assign wr_en     = v_i && !reset_i &&
                     (((state_q == e_idle) && start_ok) || ((state_q == e_store) && !buf_full));
  assign lenq_push = wr_en && last_i && !error_i;
  assign len_next  = (cnt_q == size_lp) ? cnt_q : cnt_q + one_ptr_lp;
  assign push_len  = (state_q == e_idle) ? one_ptr_lp : len_next;

  assign good_o     = good_q;
  assign bad_o      = bad_q;
  assign overflow_o = overflow_q;

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_cur_q[lg_size_p-1:0]] <= '{data: data_i, keep: keep_i, last: last_i};
    if (rd_en) mem_rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_idle;
      wr_cur_q    <= '0;
      wr_commit_q <= '0;
      cnt_q       <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      overflow_q <= 1'b0;
      if (v_i) begin
        case (state_q)
          e_idle: begin
            if (!start_ok) begin
              if (last_i) overflow_q <= 1'b1;
              else        state_q    <= e_drop;
            end else if (last_i) begin
              if (error_i) bad_q <= 1'b1;
              else begin
                wr_cur_q    <= wr_cur_q + one_ptr_lp;
                wr_commit_q <= wr_cur_q + one_ptr_lp;
                good_q      <= 1'b1;
              end
            end else begin
              wr_cur_q <= wr_cur_q + one_ptr_lp;
              cnt_q    <= one_ptr_lp;
              state_q  <= e_store;
            end
          end
          e_store: begin
            if (buf_full) begin
              wr_cur_q <= wr_commit_q;
              if (last_i) begin
                overflow_q <= 1'b1;
                state_q    <= e_idle;
              end else state_q <= e_drop;
            end else if (last_i) begin
              state_q <= e_idle;
              if (error_i) begin
                wr_cur_q <= wr_commit_q;
                bad_q    <= 1'b1;
              end else begin
                wr_cur_q    <= wr_cur_q + one_ptr_lp;
                wr_commit_q <= wr_cur_q + one_ptr_lp;
                good_q      <= 1'b1;
              end
            end else begin
              wr_cur_q <= wr_cur_q + one_ptr_lp;
              cnt_q    <= len_next;
            end
          end
          e_drop: begin
            if (last_i) begin
              overflow_q <= 1'b1;
              state_q    <= e_idle;
            end
          end
          default: state_q <= e_idle;
        endcase
      end
    end
  end

  // Length queue: head is the frame currently leaving; pops with its last beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lenq_wptr_q <= '0;
      lenq_rptr_q <= '0;
      lenq_cnt_q  <= '0;
    end else begin
      if (lenq_push) begin
        lenq_mem[lenq_wptr_q] <= push_len;
        lenq_wptr_q           <= lenq_wptr_q + lg_frames_p'(1);
      end
      if (lenq_pop) lenq_rptr_q <= lenq_rptr_q + lg_frames_p'(1);
      lenq_cnt_q <= lenq_cnt_q + (lg_frames_p+1)'(lenq_push) - (lg_frames_p+1)'(lenq_pop);
    end
  end

  assign len_o = lenq_mem[lenq_rptr_q];

  bsg_store_and_forward_rd_pipe #(
    .width_p  (width_p),
    .lg_size_p(lg_size_p)
  ) rd_pipe (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .wr_commit_i(wr_commit_q),
    .rd_ptr_o   (rd_ptr),
    .rd_en_o    (rd_en),
    .rd_addr_o  (rd_addr),
    .rd_data_i  (mem_rdata_q),
    .data_o     (data_o),
    .keep_o     (keep_o),
    .v_o        (v_o),
    .last_o     (last_o),
    .ready_and_i(ready_and_i),
    .lenq_pop_o (lenq_pop)
  );

`ifdef BSG_STORE_AND_FORWARD_STATS_EN
  logic [31:0] good_cnt_q, bad_cnt_q, overflow_cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || stats_clear_i) begin
      good_cnt_q     <= '0;
      bad_cnt_q      <= '0;
      overflow_cnt_q <= '0;
    end else begin
      if (good_q && !(&good_cnt_q))         good_cnt_q     <= good_cnt_q + 32'd1;
      if (bad_q && !(&bad_cnt_q))           bad_cnt_q      <= bad_cnt_q + 32'd1;
      if (overflow_q && !(&overflow_cnt_q)) overflow_cnt_q <= overflow_cnt_q + 32'd1;
    end
  end

  assign good_cnt_o     = good_cnt_q;
  assign bad_cnt_o      = bad_cnt_q;
  assign overflow_cnt_o = overflow_cnt_q;
`endif

endmodule
